// File: rtl/pause_dim_pkg.sv
// Shared types and constant helpers for the pause/dim controller.
package pause_dim_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      FADE_OUT,
      DIMMED,
      FADE_IN
   } state_t;

   function automatic int lvl_w(input int steps);
      return $clog2(steps + 1);
   endfunction

   function automatic logic [31:0] calc_dim_cyc(input longint clk_hz, input longint dim_sec);
      return 32'(clk_hz * dim_sec);
   endfunction

   localparam logic [31:0] DIM_CYC_DEF = calc_dim_cyc(48000000, 10);

endpackage

// File: rtl/pause_dim_ctrl_rgb_dim_scale.sv
// Single-channel brightness scaler: out = in - (in*level >> (log2(steps)+1)).
module rgb_dim_scale
   import pause_dim_pkg::*;
#(
   parameter int W          = 3,
   parameter int FADE_STEPS = 4
) (
   input  logic [W-1:0]                    chan_in,
   input  logic [lvl_w(FADE_STEPS)-1:0]    level,
   output logic [W-1:0]                    chan_out
);

   localparam int SH = $clog2(FADE_STEPS) + 1;

   // level is at most 16, so W+5 bits hold the product without overflow
   logic [W+4:0] prod;
   logic [W+4:0] cut;

   assign prod     = (W+5)'(chan_in) * (W+5)'(level);
   assign cut      = prod >> SH;
   assign chan_out = W'((W+5)'(chan_in) - cut);

endmodule

// File: rtl/pause_dim_ctrl.sv
// Merges user and system pause sources and fades the picture to half brightness
// after a long user pause.
//
// state    | meaning
// IDLE     | not user-paused, full brightness
// COUNT    | user-paused, waiting for the idle timer to expire
// FADE_OUT | stepping dim_level up every FADE_FRAMES vsyncs
// DIMMED   | held at half brightness
// FADE_IN  | stepping dim_level down every FADE_FRAMES vsyncs
module pause_dim_ctrl
   import pause_dim_pkg::*;
#(
   parameter int CLK_HZ      = 48000000,
   parameter int DIM_SEC     = 10,
   parameter int NSRC        = 2,
   parameter int RW          = 3,
   parameter int GW          = 3,
   parameter int BW          = 2,
   parameter int FADE_STEPS  = 4,
   parameter int FADE_FRAMES = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           btn_pause,
   input  logic [NSRC-1:0]                src_req,
   input  logic                           osd_open,
   input  logic                           osd_pause_en,
   input  logic                           vs,
   input  logic [RW+GW+BW-1:0]            rgb_in,
   output logic [RW+GW+BW-1:0]            rgb_out,
   output logic                           pause,
   output logic                           pause_user,
   output logic [lvl_w(FADE_STEPS)-1:0]   dim_level
);

   localparam int              PW      = RW + GW + BW;
   localparam int              LW      = lvl_w(FADE_STEPS);
   localparam int              FW      = $clog2(FADE_FRAMES + 1);
   localparam logic [31:0]     DIM_CYC = calc_dim_cyc(CLK_HZ, DIM_SEC);
   localparam logic [FW-1:0]   FC_LAST = FW'(FADE_FRAMES - 1);
   localparam logic [LW-1:0]   LVL_PRE = LW'(FADE_STEPS - 1);

   state_t         state;
   logic [31:0]    timer;
   logic [FW-1:0]  fcnt;
   logic           btn_q;
   logic           vs_q;
   logic           edge_ok;
   logic           btn_rise;
   logic           vs_rise;
   logic           frame_done;
   logic [PW-1:0]  rgb_dim;

   // edge_ok masks the first clk after reset so a button held through reset
   // does not count as a press
   assign btn_rise   = btn_pause & ~btn_q & edge_ok;
   assign vs_rise    = vs & ~vs_q;
   assign frame_done = vs_rise && (fcnt == FC_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_q      <= 1'b0;
         vs_q       <= 1'b0;
         edge_ok    <= 1'b0;
         pause_user <= 1'b0;
         pause      <= 1'b0;
         timer      <= '0;
      end else begin
         btn_q   <= btn_pause;
         vs_q    <= vs;
         edge_ok <= 1'b1;
         if (btn_rise)
            pause_user <= ~pause_user;
         pause <= pause_user | (|src_req) | (osd_open & osd_pause_en);
         if (!pause_user)
            timer <= '0;
         else if (timer != DIM_CYC)
            timer <= timer + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         fcnt      <= '0;
         dim_level <= '0;
      end else begin
         case (state)
            IDLE: begin
               fcnt      <= '0;
               dim_level <= '0;
               if (pause_user)
                  state <= COUNT;
            end
            COUNT: begin
               fcnt <= '0;
               if (!pause_user)
                  state <= IDLE;
               else if (timer == DIM_CYC)
                  state <= FADE_OUT;
            end
            FADE_OUT: begin
               // a resume takes priority over a vsync step on the same clk
               if (!pause_user) begin
                  state <= FADE_IN;
                  fcnt  <= '0;
               end else if (frame_done) begin
                  fcnt      <= '0;
                  dim_level <= dim_level + 1'b1;
                  if (dim_level == LVL_PRE)
                     state <= DIMMED;
               end else if (vs_rise) begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            DIMMED: begin
               fcnt <= '0;
               if (!pause_user)
                  state <= FADE_IN;
            end
            FADE_IN: begin
               if (dim_level == '0) begin
                  fcnt  <= '0;
                  state <= pause_user ? COUNT : IDLE;
               end else if (frame_done) begin
                  fcnt      <= '0;
                  dim_level <= dim_level - 1'b1;
               end else if (vs_rise) begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               fcnt      <= '0;
               dim_level <= '0;
            end
         endcase
      end
   end

   rgb_dim_scale #(.W(RW), .FADE_STEPS(FADE_STEPS)) u_scale_r (
      .chan_in  (rgb_in[RW-1:0]),
      .level    (dim_level),
      .chan_out (rgb_dim[RW-1:0])
   );

   rgb_dim_scale #(.W(GW), .FADE_STEPS(FADE_STEPS)) u_scale_g (
      .chan_in  (rgb_in[RW +: GW]),
      .level    (dim_level),
      .chan_out (rgb_dim[RW +: GW])
   );

   rgb_dim_scale #(.W(BW), .FADE_STEPS(FADE_STEPS)) u_scale_b (
      .chan_in  (rgb_in[RW+GW +: BW]),
      .level    (dim_level),
      .chan_out (rgb_dim[RW+GW +: BW])
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rgb_out <= '0;
      else
         rgb_out <= rgb_dim;
   end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Scenario bench for pause_dim_ctrl with a short idle timer and fast fade.
module tb_pause_dim_ctrl;
   import pause_dim_pkg::*;

   localparam int NSRC = 2;
   localparam int PW   = 8;
   localparam int LW   = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            btn_pause;
   logic [NSRC-1:0] src_req;
   logic            osd_open;
   logic            osd_pause_en;
   logic            vs;
   logic [PW-1:0]   rgb_in;
   logic [PW-1:0]   rgb_out;
   logic            pause;
   logic            pause_user;
   logic [LW-1:0]   dim_level;

   int              checks = 0;
   int              failures = 0;
   int unsigned     cyc = 0;
   logic [PW-1:0]   sb_q[$];

   pause_dim_ctrl #(
      .CLK_HZ(100), .DIM_SEC(1), .NSRC(NSRC), .RW(3), .GW(3), .BW(2),
      .FADE_STEPS(4), .FADE_FRAMES(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_pause    (btn_pause),
      .src_req      (src_req),
      .osd_open     (osd_open),
      .osd_pause_en (osd_pause_en),
      .vs           (vs),
      .rgb_in       (rgb_in),
      .rgb_out      (rgb_out),
      .pause        (pause),
      .pause_user   (pause_user),
      .dim_level    (dim_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic vs_pulse();
      vs = 1'b1;
      tick();
      vs = 1'b0;
      tick();
   endtask

   task automatic btn_pulse();
      btn_pause = 1'b1;
      tick();
      btn_pause = 1'b0;
   endtask

   task automatic wait_state(input state_t s, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= bound; i++) begin
         if (dut.state == s) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      btn_pause = 1'b0;
      src_req = '0;
      osd_open = 1'b0;
      osd_pause_en = 1'b0;
      vs = 1'b0;
      rgb_in = '0;
      tick();
      tick();
      #2 reset = 1'b0;
      tick();
      tick();
      sb_q.delete();
   endtask

   task automatic test_reset();
      reset_dut();
      reset = 1'b1;
      tick();
      checks++; if (rgb_out !== '0) begin failures++; $display("FAIL reset_rgb got=%0h exp=0", rgb_out); end
      checks++; if (pause !== 1'b0) begin failures++; $display("FAIL reset_pause got=%b exp=0", pause); end
      checks++; if (pause_user !== 1'b0) begin failures++; $display("FAIL reset_pause_user got=%b exp=0", pause_user); end
      checks++; if (dim_level !== '0) begin failures++; $display("FAIL reset_dim got=%0d exp=0", dim_level); end
      checks++; if (dut.timer !== 32'd0) begin failures++; $display("FAIL reset_timer got=%0d exp=0", dut.timer); end
      checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
      #2 reset = 1'b0;
      tick();
   endtask

   task automatic test_fade_out();
      int unsigned   c0;
      bit            ok;
      logic [PW-1:0] pix_tab [3];
      logic [PW-1:0] exp_tab [3];
      logic [PW-1:0] exp_v;
      pix_tab[0] = {2'd3, 3'd7, 3'd7}; exp_tab[0] = {2'd2, 3'd4, 3'd4};
      pix_tab[1] = {2'd1, 3'd2, 3'd5}; exp_tab[1] = {2'd1, 3'd1, 3'd3};
      pix_tab[2] = {2'd0, 3'd0, 3'd1}; exp_tab[2] = {2'd0, 3'd0, 3'd1};
      reset_dut();
      btn_pause = 1'b1;
      tick();
      checks++; if (pause_user !== 1'b1) begin failures++; $display("FAIL toggle_pause_user got=%b exp=1", pause_user); end
      checks++; if (pause !== 1'b0) begin failures++; $display("FAIL pause_early got=%b exp=0", pause); end
      c0 = cyc;
      btn_pause = 1'b0;
      tick();
      checks++; if (pause !== 1'b1) begin failures++; $display("FAIL pause_rise got=%b exp=1", pause); end
      wait_state(FADE_OUT, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL fade_out_timeout got=%0d exp=%0d", dut.state, FADE_OUT); end
      checks++; if (cyc - c0 !== 32'd101) begin failures++; $display("FAIL fade_out_delay got=%0d exp=101", cyc - c0); end
      checks++; if (dut.timer !== 32'd100) begin failures++; $display("FAIL fade_out_timer got=%0d exp=100", dut.timer); end
      for (int e = 1; e <= 8; e++) begin
         vs_pulse();
         checks++;
         if (dim_level !== LW'(e / 2)) begin
            failures++; $display("FAIL fade_out_level edge=%0d got=%0d exp=%0d", e, dim_level, e / 2);
         end
      end
      checks++; if (dut.state !== DIMMED) begin failures++; $display("FAIL dimmed_state got=%0d exp=%0d", dut.state, DIMMED); end
      for (int i = 0; i < 3; i++) begin
         rgb_in = pix_tab[i];
         sb_q.push_back(exp_tab[i]);
         tick();
         exp_v = sb_q.pop_front();
         checks++;
         if (rgb_out !== exp_v) begin failures++; $display("FAIL dim_pixel idx=%0d got=%0h exp=%0h", i, rgb_out, exp_v); end
      end
   endtask

   task automatic test_fade_in();
      bit ok;
      reset_dut();
      btn_pulse();
      wait_state(FADE_OUT, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL fi_fade_out_timeout got=%0d exp=%0d", dut.state, FADE_OUT); end
      repeat (4) vs_pulse();
      checks++; if (dim_level !== 3'd2) begin failures++; $display("FAIL fi_level2 got=%0d exp=2", dim_level); end
      btn_pulse();
      tick();
      checks++; if (dut.state !== FADE_IN) begin failures++; $display("FAIL fi_state got=%0d exp=%0d", dut.state, FADE_IN); end
      checks++; if (dim_level !== 3'd2) begin failures++; $display("FAIL fi_hold got=%0d exp=2", dim_level); end
      repeat (2) vs_pulse();
      checks++; if (dim_level !== 3'd1) begin failures++; $display("FAIL fi_level1 got=%0d exp=1", dim_level); end
      repeat (2) vs_pulse();
      checks++; if (dim_level !== 3'd0) begin failures++; $display("FAIL fi_level0 got=%0d exp=0", dim_level); end
      wait_state(IDLE, 5, ok);
      checks++; if (!ok) begin failures++; $display("FAIL fi_idle_timeout got=%0d exp=%0d", dut.state, IDLE); end
      checks++; if (dut.timer !== 32'd0) begin failures++; $display("FAIL fi_timer got=%0d exp=0", dut.timer); end
      checks++; if (pause !== 1'b0) begin failures++; $display("FAIL fi_pause got=%b exp=0", pause); end
   endtask

   task automatic test_src_req();
      logic [PW-1:0] exp_v;
      reset_dut();
      src_req = 2'b10;
      for (int i = 0; i < 500; i++) begin
         rgb_in = PW'($urandom);
         sb_q.push_back(rgb_in);
         tick();
         exp_v = sb_q.pop_front();
         checks++; if (rgb_out !== exp_v) begin failures++; $display("FAIL src_passthru cyc=%0d got=%0h exp=%0h", i, rgb_out, exp_v); end
         checks++; if (pause !== 1'b1) begin failures++; $display("FAIL src_pause cyc=%0d got=%b exp=1", i, pause); end
         checks++; if (dim_level !== '0) begin failures++; $display("FAIL src_dim cyc=%0d got=%0d exp=0", i, dim_level); end
      end
      checks++; if (pause_user !== 1'b0) begin failures++; $display("FAIL src_pause_user got=%b exp=0", pause_user); end
      src_req = '0;
      tick();
      checks++; if (pause !== 1'b0) begin failures++; $display("FAIL src_release got=%b exp=0", pause); end
   endtask

   task automatic test_osd();
      reset_dut();
      osd_open = 1'b1;
      osd_pause_en = 1'b0;
      tick();
      tick();
      checks++; if (pause !== 1'b0) begin failures++; $display("FAIL osd_disabled got=%b exp=0", pause); end
      osd_pause_en = 1'b1;
      tick();
      checks++; if (pause !== 1'b1) begin failures++; $display("FAIL osd_enabled got=%b exp=1", pause); end
      checks++; if (dim_level !== '0) begin failures++; $display("FAIL osd_dim got=%0d exp=0", dim_level); end
      osd_open = 1'b0;
      osd_pause_en = 1'b0;
      tick();
   endtask

   task automatic test_repause();
      bit          ok;
      int unsigned c0;
      reset_dut();
      btn_pulse();
      wait_state(FADE_OUT, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rp_fade_out_timeout got=%0d exp=%0d", dut.state, FADE_OUT); end
      repeat (8) vs_pulse();
      btn_pulse();
      tick();
      repeat (2) vs_pulse();
      checks++; if (dim_level !== 3'd3) begin failures++; $display("FAIL rp_level3 got=%0d exp=3", dim_level); end
      btn_pulse();
      c0 = cyc;
      checks++; if (pause_user !== 1'b1) begin failures++; $display("FAIL rp_pause_user got=%b exp=1", pause_user); end
      for (int p = 1; p <= 3; p++) begin
         repeat (2) vs_pulse();
         checks++;
         if (dim_level !== LW'(3 - p)) begin failures++; $display("FAIL rp_fade_in step=%0d got=%0d exp=%0d", p, dim_level, 3 - p); end
      end
      wait_state(COUNT, 5, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rp_count_timeout got=%0d exp=%0d", dut.state, COUNT); end
      wait_state(FADE_OUT, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rp_refade_timeout got=%0d exp=%0d", dut.state, FADE_OUT); end
      checks++; if (cyc - c0 !== 32'd101) begin failures++; $display("FAIL rp_delay got=%0d exp=101", cyc - c0); end
      checks++; if (dut.timer !== 32'd100) begin failures++; $display("FAIL rp_timer got=%0d exp=100", dut.timer); end
   endtask

   task automatic test_async_reset();
      bit ok;
      reset_dut();
      rgb_in = '1;
      btn_pulse();
      wait_state(FADE_OUT, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL ar_fade_out_timeout got=%0d exp=%0d", dut.state, FADE_OUT); end
      repeat (8) vs_pulse();
      checks++; if (dut.state !== DIMMED) begin failures++; $display("FAIL ar_dimmed got=%0d exp=%0d", dut.state, DIMMED); end
      checks++; if (rgb_out !== {2'd2, 3'd4, 3'd4}) begin failures++; $display("FAIL ar_pre_pixel got=%0h exp=%0h", rgb_out, {2'd2, 3'd4, 3'd4}); end
      #3 reset = 1'b1;
      btn_pause = 1'b1;
      #1;
      checks++; if (rgb_out !== '0) begin failures++; $display("FAIL ar_rgb got=%0h exp=0", rgb_out); end
      checks++; if (pause !== 1'b0) begin failures++; $display("FAIL ar_pause got=%b exp=0", pause); end
      checks++; if (pause_user !== 1'b0) begin failures++; $display("FAIL ar_pause_user got=%b exp=0", pause_user); end
      checks++; if (dim_level !== '0) begin failures++; $display("FAIL ar_dim got=%0d exp=0", dim_level); end
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      checks++; if (rgb_out !== '0) begin failures++; $display("FAIL ar_rgb_release got=%0h exp=0", rgb_out); end
      repeat (3) tick();
      checks++; if (pause_user !== 1'b0) begin failures++; $display("FAIL ar_held_btn got=%b exp=0", pause_user); end
      btn_pause = 1'b0;
      tick();
      btn_pause = 1'b1;
      tick();
      checks++; if (pause_user !== 1'b1) begin failures++; $display("FAIL ar_new_edge got=%b exp=1", pause_user); end
      btn_pause = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      btn_pause = 1'b0;
      src_req = '0;
      osd_open = 1'b0;
      osd_pause_en = 1'b0;
      vs = 1'b0;
      rgb_in = '0;
      test_reset();
      test_fade_out();
      test_fade_in();
      test_src_req();
      test_osd();
      test_repause();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pause_dim_ctrl.md
Name: pause_dim_ctrl

Overview:
- Parametrised successor to the ad-hoc pause/dim logic in the arcade top levels.
- Merges user pause toggle, N system pause requests (hiscore access, OSD-open policy, etc.) into one registered pause.
- After a configurable idle time in user pause, fades video down in FADE_STEPS vsync-timed steps to half brightness; fades back up on resume.
- Sits between the core's RGB output and arcade_video, one instance per core top.

Parameters:
- CLK_HZ, 48000000, system clock frequency.
- DIM_SEC, 10, seconds of user pause before fade-out starts.
- NSRC, 2, number of system pause request inputs.
- RW, 3, red channel width.
- GW, 3, green channel width.
- BW, 2, blue channel width.
- FADE_STEPS, 4, fade levels from full to half brightness; power of two, 1..16.
- FADE_FRAMES, 8, vsync rising edges per fade step, at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- btn_pause  in  1  level pause button from joystick; rising edge toggles.
- src_req  in  NSRC  system pause requests, active-high level.
- osd_open  in  1  OSD visible.
- osd_pause_en  in  1  pause-on-OSD option enabled.
- vs  in  1  vertical sync, active-high; rising edges time the fade.
- rgb_in  in  RW+GW+BW  packed {b,g,r} pixel from core.
- rgb_out  out  RW+GW+BW  packed {b,g,r} dimmed pixel.
- pause  out  1  combined pause to core, active-high.
- pause_user  out  1  user toggle state.
- dim_level  out  $clog2(FADE_STEPS+1)  current fade level, 0 = full brightness.

Behaviour:
- Reset values: all outputs 0, state IDLE, timer 0, frame counter 0, edge-detect registers 0.
- Edge detects on btn_pause and vs are registered. A btn_pause 0->1 toggles pause_user on the following clk.
- pause is registered: pause <= pause_user | (|src_req) | (osd_open & osd_pause_en). Latency is 1 clk from the input, 2 clk from the btn_pause edge.
- Only pause_user drives dimming. src_req and OSD never dim.
- DIM_CYC = CLK_HZ*DIM_SEC. Timer is 32 bits. It increments while pause_user=1 and saturates at DIM_CYC. It clears to 0 on the clk that pause_user=0.
- FSM:
  - IDLE: dim_level=0. Go to COUNT when pause_user=1.
  - COUNT: go to IDLE if pause_user=0. Go to FADE_OUT when timer==DIM_CYC.
  - FADE_OUT: frame counter counts vs rising edges. On the FADE_FRAMES-th edge, dim_level+1 and the counter clears. Go to DIMMED when dim_level reaches FADE_STEPS. If pause_user=0, go to FADE_IN holding the current dim_level.
  - DIMMED: hold FADE_STEPS. Go to FADE_IN when pause_user=0.
  - FADE_IN: step dim_level-1 every FADE_FRAMES vsync edges. At 0, go to IDLE if pause_user=0, or to COUNT if pause_user=1; the timer has restarted from 0 since re-pause.
- Frame counter clears on every state change.
- A vs edge and a pause_user change on the same clk: the state change wins and no step is taken.
- Dimming, per channel of width W: out = in - ((in * dim_level) >> (log2(FADE_STEPS)+1)).
  - Intermediate product is W+5 bits, with no overflow.
  - dim_level=FADE_STEPS gives in - in/2, floor.
  - dim_level=0 gives a bit-exact pass-through.
- rgb_out is registered, 1-clk latency, always (also when not paused).
- Asynchronous reset mid-fade returns to full brightness immediately, with rgb_out=0 until the first clk after release.

Decomposition:
- Package pause_dim_pkg holds:
  - the state enum (IDLE, COUNT, FADE_OUT, DIMMED, FADE_IN);
  - the function lvl_w(steps) returning $clog2(steps+1);
  - the localparam computation of DIM_CYC.
- Sub-module rgb_dim_scale (parameter W): a combinational single-channel scaler, instantiated three times. The output register stays in the parent.

Test Plan:
- CLK_HZ=100, DIM_SEC=1, FADE_STEPS=4, FADE_FRAMES=2. Pulse btn_pause, hold pause_user. Check:
  - pause rises 2 clk after the edge;
  - FADE_OUT is entered at timer=100;
  - dim_level goes 1,2,3,4 on vs edges 2,4,6,8;
  - rgb_in r=7,g=7,b=3 gives r=4,g=4,b=2 at level 4.
- Second btn_pause edge during FADE_OUT at level 2 -> FADE_IN; level steps 1 then 0 at 2-edge intervals, then IDLE; timer reads 0.
- src_req[1]=1 for 500 clk with pause_user=0 -> pause=1 throughout, dim_level stays 0, rgb_out equals rgb_in delayed 1 clk.
- osd_open=1 with osd_pause_en=0 -> pause=0. Set osd_pause_en=1 -> pause=1 after 1 clk.
- Re-pause during FADE_IN at level 3 -> fade continues to 0, then COUNT. A fresh 100-clk delay elapses before FADE_OUT.
- Assert reset while DIMMED, asynchronous, mid-cycle -> rgb_out, pause, pause_user and dim_level are 0 immediately. After release, btn_pause held high does not toggle until a new rising edge.
